cmos_pll_ctrl: RTL and testbench
================================

# cmos_pll_ctrl

Power-up and lock-supervision sequencer for the camera clock PLL and the CMOS sensor. It runs on the free-running 50 MHz board clock. It holds the PLL in reset, waits for a stable lock with timeout and retry, then releases the sensor's power-down and reset pins with the required settling delays. On lock loss it drops the sensor back into reset and restarts the PLL, and it signals `ready` to the SCCB init engine and capture path only when the 24 MHz sensor clock is trustworthy.

## Interface
Parameters:
- `PLL_RST_CYC`, default 100: cycles `pll_reset` is held high per attempt (2 µs).
- `LOCK_TIMEOUT_CYC`, default 50000: maximum cycles to wait for lock per attempt (1 ms).
- `LOCK_STABLE_CYC`, default 1000: cycles lock must stay continuously high before the sensor is released.
- `PWDN_CYC`, default 50000: cycles from `cmos_pwdn` low to `cmos_rst_n` high.
- `RST_CYC`, default 1000000: cycles from `cmos_rst_n` high to `ready` (20 ms).
- `MAX_RETRY`, default 3: PLL re-reset attempts after timeout before fault.

Every `*_CYC` value is between 1 and 2^20-1. `MAX_RETRY` is between 0 and 7.

Ports:
- `clk`, input, 1 bit: 50 MHz board clock.
- `resetn`, input, 1 bit: asynchronous active-low reset.
- `restart`, input, 1 bit: single-cycle pulse that forces a full re-sequence from any state.
- `pll_lock`, input, 1 bit: PLL LOCK, asynchronous to `clk`.
- `pll_reset`, output, 1 bit: PLL RESET, active high.
- `cmos_pwdn`, output, 1 bit: sensor power-down, active high.
- `cmos_rst_n`, output, 1 bit: sensor reset, active low.
- `ready`, output, 1 bit: clock stable and sensor out of reset.
- `fault`, output, 1 bit: retries exhausted.
- `state`, output, 3 bits: current FSM state, for debug.
- `lock_loss_cnt`, output, 8 bits: saturating count of lock losses after `ready` (see Configuration).

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. The FSM uses only `lock_s`.
- A single 20-bit counter `cnt` is cleared on every state entry. A timed state of length N exits on the cycle where `cnt == N-1`, so it lasts exactly N cycles.
- `retry` is a 3-bit counter.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, PWDN_WAIT=3, RST_WAIT=4, RUN=5, FAULT=6.
- PLL_RST: `pll_reset`=1, `cmos_pwdn`=1, `cmos_rst_n`=0. After `PLL_RST_CYC` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1, go to STABLE.
  - Otherwise, after `LOCK_TIMEOUT_CYC` cycles: if `retry == MAX_RETRY`, go to FAULT; else `retry`++ and go to PLL_RST.
- STABLE:
  - If `lock_s`=0, go to WAIT_LOCK. The timeout restarts and `retry` is unchanged.
  - After `LOCK_STABLE_CYC` cycles, go to PWDN_WAIT.
- PWDN_WAIT: `cmos_pwdn`=0, `cmos_rst_n`=0. After `PWDN_CYC` cycles, go to RST_WAIT.
- RST_WAIT: `cmos_pwdn`=0, `cmos_rst_n`=1. After `RST_CYC` cycles, go to RUN.
- RUN: `ready`=1. `retry` is cleared on entry.
- Lock loss: `lock_s`=0 in PWDN_WAIT, RST_WAIT or RUN goes to PLL_RST. `lock_loss_cnt` increments (saturating at 255) only when the loss occurs in RUN.
- FAULT: `pll_reset`=1, `cmos_pwdn`=1, `cmos_rst_n`=0, `fault`=1. FAULT is left only via `restart`.
- `restart`=1 in any state: go to PLL_RST, clear `retry` and `fault`. `lock_loss_cnt` is kept. `restart` has priority over all other transitions in the same cycle.
- All outputs are registered and decoded from the next state, so they change on the same edge as `state`.

## Timing
- Reset values: `pll_reset`=1, `cmos_pwdn`=1, `cmos_rst_n`=0, `ready`=0, `fault`=0, `state`=0, `retry`=0, `lock_loss_cnt`=0, synchronizer flops=0.
- Synchronizer latency: a `pll_lock` change is seen by the FSM 2 cycles later.
- From the first edge sampling `pll_lock`=1 in WAIT_LOCK, `ready` rises after 2 + `LOCK_STABLE_CYC` + `PWDN_CYC` + `RST_CYC` cycles.
- From the edge sampling `pll_lock`=0 in RUN, `ready`=0 and `cmos_rst_n`=0 follow 2 cycles later, together with `pll_reset`=1.
- `resetn` asserted mid-sequence forces all outputs to their reset values immediately (asynchronously). Deassertion is synchronized externally.
- Sensor sequencing invariant: `cmos_rst_n`=1 only when `cmos_pwdn`=0 and state is RST_WAIT or RUN.

## Configuration
- `CMOS_PLL_CTRL_LOSS_CNT_EN`:
  - Defined: the 8-bit saturating lock-loss counter is built as described.
  - Undefined: no counter register exists, `lock_loss_cnt` is tied to 8'd0, and all other behaviour is identical.

## Test plan
All scenarios use `PLL_RST_CYC`=4, `LOCK_TIMEOUT_CYC`=20, `LOCK_STABLE_CYC`=8, `PWDN_CYC`=6, `RST_CYC`=10, `MAX_RETRY`=2.
- Nominal: release `resetn`, raise `pll_lock` at cycle 10 -> `pll_reset` low at cycle 4; `cmos_pwdn` falls 10 cycles after lock is first sampled; `cmos_rst_n` rises 6 cycles later; `ready` rises 26 cycles after lock is first sampled; `state`=5.
- Timeout: `pll_lock` held 0 -> 3 `pll_reset` pulses of 4 cycles each; `fault`=1 and `state`=6 from cycle 72; outputs are then held.
- Glitch in STABLE: lock high 5 cycles, low 3 cycles, then high -> state returns to WAIT_LOCK; `cmos_pwdn` stays 1; `ready` rises 26 cycles after the second lock sample.
- Loss in RUN: drop `pll_lock` while `ready`=1 -> 2 cycles later `ready`=0, `cmos_rst_n`=0, `cmos_pwdn`=1, `pll_reset`=1, `lock_loss_cnt`=1 (0 without the macro); 300 losses saturate the counter at 255.
- Restart: pulse `restart` in FAULT, and again in RST_WAIT -> next cycle `state`=0, `fault`=0, `retry`=0; the full sequence then completes normally.
- Async reset: assert `resetn` low in RUN between clock edges -> all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/cmos_pll_ctrl.sv
`default_nettype none
// ==========================================================================
// cmos_pll_ctrl : camera PLL lock supervisor and CMOS sensor power-up sequencer
// Optional lock-loss counter macro: CMOS_PLL_CTRL_LOSS_CNT_EN
// Rev 1.0
// ==========================================================================
module cmos_pll_ctrl #(
  parameter int unsigned PLL_RST_CYC      = 100,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1000,
  parameter int unsigned PWDN_CYC         = 50000,
  parameter int unsigned RST_CYC          = 1000000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       cmos_pwdn,
  output logic       cmos_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [19:0] c_PLL_RST_LAST = 20'(PLL_RST_CYC - 1);
  localparam logic [19:0] c_TIMEOUT_LAST = 20'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [19:0] c_STABLE_LAST  = 20'(LOCK_STABLE_CYC - 1);
  localparam logic [19:0] c_PWDN_LAST    = 20'(PWDN_CYC - 1);
  localparam logic [19:0] c_RST_LAST     = 20'(RST_CYC - 1);
  localparam logic [2:0]  c_MAX_RETRY    = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_PWDN_WAIT = 3'd3,
    S_RST_WAIT  = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_lock_s;
  logic [19:0] r_cnt;
  logic [2:0]  r_retry;
  logic [2:0]  w_retry_next;
  logic        w_enter;
  logic        r_pll_reset;
  logic        r_cmos_pwdn;
  logic        r_cmos_rst_n;
  logic        r_ready;
  logic        r_fault;

  // pll_lock is asynchronous to clk; the FSM only ever looks at w_lock_s
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_s = r_sync2;

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    if (restart) begin
      w_next       = S_PLL_RST;
      w_retry_next = 3'd0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == c_PLL_RST_LAST) w_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next = S_STABLE;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            if (r_retry == c_MAX_RETRY) begin
              w_next = S_FAULT;
            end else begin
              w_retry_next = r_retry + 3'd1;
              w_next       = S_PLL_RST;
            end
          end
        end
        S_STABLE: begin
          if (!w_lock_s)                   w_next = S_WAIT_LOCK;
          else if (r_cnt == c_STABLE_LAST) w_next = S_PWDN_WAIT;
        end
        S_PWDN_WAIT: begin
          if (!w_lock_s)                 w_next = S_PLL_RST;
          else if (r_cnt == c_PWDN_LAST) w_next = S_RST_WAIT;
        end
        S_RST_WAIT: begin
          if (!w_lock_s) begin
            w_next = S_PLL_RST;
          end else if (r_cnt == c_RST_LAST) begin
            w_next       = S_RUN;
            w_retry_next = 3'd0;
          end
        end
        S_RUN: begin
          if (!w_lock_s) w_next = S_PLL_RST;
        end
        S_FAULT: w_next = S_FAULT;
        default: w_next = S_PLL_RST;
      endcase
    end
  end

  // A restart re-enters PLL_RST even from PLL_RST, so it also clears the timer
  assign w_enter = restart || (w_next != r_state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= 20'd0;
      r_retry      <= 3'd0;
      r_pll_reset  <= 1'b1;
      r_cmos_pwdn  <= 1'b1;
      r_cmos_rst_n <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_enter ? 20'd0 : r_cnt + 20'd1;
      r_retry      <= w_retry_next;
      r_pll_reset  <= (w_next == S_PLL_RST) || (w_next == S_FAULT);
      r_cmos_pwdn  <= (w_next == S_PLL_RST) || (w_next == S_WAIT_LOCK) ||
                      (w_next == S_STABLE)  || (w_next == S_FAULT);
      r_cmos_rst_n <= (w_next == S_RST_WAIT) || (w_next == S_RUN);
      r_ready      <= (w_next == S_RUN);
      r_fault      <= (w_next == S_FAULT);
    end
  end

`ifdef CMOS_PLL_CTRL_LOSS_CNT_EN
  logic       w_run_loss;
  logic [7:0] r_loss_cnt;

  // A restart in the same cycle pre-empts the loss transition, so it is not counted
  assign w_run_loss = (r_state == S_RUN) && !w_lock_s && !restart;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_loss_cnt <= 8'd0;
    end else if (w_run_loss && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_reset  = r_pll_reset;
  assign cmos_pwdn  = r_cmos_pwdn;
  assign cmos_rst_n = r_cmos_rst_n;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cmos_pll_ctrl.sv
`default_nettype none
// tb_cmos_pll_ctrl : randomized scoreboard bench; a timeline model predicts every
// output change (cycle and value) and a monitor matches it against the DUT.
module tb_cmos_pll_ctrl;

  localparam int P_RST   = 4;
  localparam int P_TO    = 20;
  localparam int P_STB   = 8;
  localparam int P_PWDN  = 6;
  localparam int P_RSTW  = 10;
  localparam int P_RETRY = 2;

  localparam logic [15:0] RESET_VEC = {3'd0, 5'b11000, 8'd0};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, cmos_pwdn, cmos_rst_n, ready, fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;
  logic [15:0] obs_vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } ev_t;
  ev_t exp_q[$];

  cmos_pll_ctrl #(
    .PLL_RST_CYC(P_RST), .LOCK_TIMEOUT_CYC(P_TO), .LOCK_STABLE_CYC(P_STB),
    .PWDN_CYC(P_PWDN), .RST_CYC(P_RSTW), .MAX_RETRY(P_RETRY)
  ) dut (
    .clk(clk), .resetn(resetn), .restart(restart), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n),
    .ready(ready), .fault(fault), .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign obs_vec = {state, pll_reset, cmos_pwdn, cmos_rst_n, ready, fault, lock_loss_cnt};

  // Output pins implied by each phase of the power-up timeline
  function automatic logic [15:0] vec_of(input int ph, input int lc);
    logic pr, pd, rn, rd, ft;
    pr = (ph == 0) || (ph == 6);
    pd = (ph <= 2) || (ph == 6);
    rn = (ph == 4) || (ph == 5);
    rd = (ph == 5);
    ft = (ph == 6);
    return {3'(ph), pr, pd, rn, rd, ft, 8'(lc)};
  endfunction

  // Timeline model: phase + entry timestamp, phase ends once elapsed time reaches its length
  initial begin : model
    int ph, t_ent, retry, lossc, el, np;
    logic ls, l1, l2;
    logic [15:0] last_vec, v;
    ph = 0; t_ent = 0; retry = 0; lossc = 0; l1 = 1'b0; l2 = 1'b0;
    last_vec = RESET_VEC;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        ph = 0; t_ent = 0; retry = 0; lossc = 0; l1 = 1'b0; l2 = 1'b0;
        cyc = 0; last_vec = RESET_VEC;
      end else begin
        cyc++;
        ls = l2; l2 = l1; l1 = pll_lock;
        el = cyc - t_ent;
        np = ph;
        if (restart) begin
          np = 0; retry = 0;
        end else begin
          case (ph)
            0: if (el == P_RST) np = 1;
            1: begin
              if (ls) np = 2;
              else if (el == P_TO) begin
                if (retry == P_RETRY) np = 6;
                else begin retry++; np = 0; end
              end
            end
            2: if (!ls) np = 1; else if (el == P_STB) np = 3;
            3: if (!ls) np = 0; else if (el == P_PWDN) np = 4;
            4: if (!ls) np = 0; else if (el == P_RSTW) begin np = 5; retry = 0; end
            5: if (!ls) begin
`ifdef CMOS_PLL_CTRL_LOSS_CNT_EN
              if (lossc < 255) lossc++;
`endif
              np = 0;
            end
            default: np = 6;
          endcase
        end
        if (restart || np != ph) t_ent = cyc;
        ph = np;
        v = vec_of(ph, lossc);
        if (v != last_vec) begin
          exp_q.push_back('{cyc: cyc, vec: v});
          last_vec = v;
        end
      end
    end
  end

  initial begin : monitor
    logic [15:0] last_obs;
    ev_t e;
    last_obs = RESET_VEC;
    forever begin
      @(negedge clk);
      checks++;
      if (cmos_rst_n && (cmos_pwdn || !(state == 3'd4 || state == 3'd5))) begin
        failures++;
        $display("FAIL sensor_invariant cyc=%0d actual rst_n=%b pwdn=%b state=%0d required rst_n=0 unless pwdn=0 in state 4/5",
                 cyc, cmos_rst_n, cmos_pwdn, state);
      end
      if (!resetn) begin
        exp_q.delete();
        last_obs = obs_vec;
      end else if (obs_vec != last_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=%h (no change)", cyc, obs_vec, last_obs);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec != obs_vec) begin
            failures++;
            $display("FAIL output_event cyc=%0d actual=%h required=%h at cyc=%0d", cyc, obs_vec, e.vec, e.cyc);
          end
        end
        last_obs = obs_vec;
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event cyc=%0d actual=%h required=%h at cyc=%0d", cyc, obs_vec, e.vec, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string what);
    int k;
    k = 0;
    while (state != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (state != s) begin
      failures++;
      $display("FAIL %s timeout actual_state=%0d required_state=%0d", what, state, s);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick(2);
    #1;
    checks++;
    if (obs_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values actual=%h required=%h", obs_vec, RESET_VEC);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Nominal bring-up with lock arriving around cycle 10
    tick(9 + $urandom_range(0, 3));
    pll_lock = 1'b1;
    wait_state(3'd5, 200, "nominal_ready");

    // Repeated losses in RUN, some with an extra drop at a random point of re-sequencing
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3));
      pll_lock = 1'b0;
      tick($urandom_range(1, 4));
      pll_lock = 1'b1;
      tick(3);
      if (i % 8 == 0) begin
        tick($urandom_range(2, 40));
        pll_lock = 1'b0;
        tick($urandom_range(1, 3));
        pll_lock = 1'b1;
      end
      wait_state(3'd5, 300, "relock_ready");
    end

    // Lock glitch while in STABLE
    pll_lock = 1'b0;
    pulse_restart();
    wait_state(3'd1, 50, "glitch_wait_lock");
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    wait_state(3'd5, 200, "glitch_ready");

    // Lock never arrives: retries exhaust into FAULT, which then holds
    pll_lock = 1'b0;
    pulse_restart();
    wait_state(3'd6, 200, "timeout_fault");
    tick(20);

    // Restart out of FAULT, then again from RST_WAIT
    pulse_restart();
    tick($urandom_range(0, 15));
    pll_lock = 1'b1;
    wait_state(3'd4, 200, "reach_rst_wait");
    tick($urandom_range(0, 8));
    pulse_restart();
    wait_state(3'd5, 200, "restart_ready");

    // Asynchronous reset between clock edges while in RUN
    tick(3);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (obs_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset actual=%h required=%h", obs_vec, RESET_VEC);
    end
    tick(2);
    resetn = 1'b1;
    wait_state(3'd5, 200, "post_reset_ready");
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
